// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   - uart_state_e   : receiver FSM state encoding
//   - OVERSAMPLE_DEF : default oversample ticks per bit
//   - VOTE_TICK_*    : tick numbers (1-based within a bit) sampled for the 2-of-3 vote
//   - DATA_BITS, FRAME_BITS_* : frame geometry with and without the parity bit
//   - maj3()         : 2-of-3 majority helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE_DEF   = 16;
  localparam int VOTE_TICK_A      = 7;
  localparam int VOTE_TICK_B      = 8;
  localparam int VOTE_TICK_C      = 9;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS_PAR   = 11;
  localparam int FRAME_BITS_NOPAR = 10;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_ovs_tick.sv
// uart_ovs_tick: oversample tick generator.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   restart_i : clears the divider so the next tick lands OVS_DIV cycles later
//   tick_o    : one-cycle pulse every OVS_DIV cycles
module uart_ovs_tick #(
  parameter int OVS_DIV = 814
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OVS_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver (start, 8 data LSB first,
// optional even parity, stop), 2-of-3 majority vote per bit.
// Build option: define UART_RX_PARITY_EN for the 11-bit frame with parity;
// undefined gives a 10-bit frame and check_parity tied to 1.
// Ports:
//   CLOCK_125_p  : clock
//   rst          : asynchronous active-low reset
//   Rx           : serial line, idle high, asynchronous
//   rx_ready     : consumer accepts the byte
//   rx_data      : received byte
//   rx_valid     : rx_data holds an unconsumed byte
//   check_parity : 1 = no parity error on the current byte
//   frame_err    : stop bit sampled low on the current byte
//   overrun      : sticky, a completed byte was dropped
//   dbg_state    : current FSM state
// Handshake: a byte transfers on every clock edge where rx_valid && rx_ready;
// rx_valid then drops unless a new byte completes in that same cycle, in
// which case the new byte loads and rx_valid stays high. A byte completing
// while rx_valid=1 and rx_ready=0 is dropped and sets overrun.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int OVS_DIV    = 814,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic        CLOCK_125_p,
  input  logic        rst,
  input  logic        Rx,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        check_parity,
  output logic        frame_err,
  output logic        overrun,
  output uart_state_e dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE + 1);
  localparam logic [TW-1:0] T_A   = TW'(VOTE_TICK_A);
  localparam logic [TW-1:0] T_B   = TW'(VOTE_TICK_B);
  localparam logic [TW-1:0] T_C   = TW'(VOTE_TICK_C);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d, tick_num;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          samp_a_q, samp_a_d, samp_b_q, samp_b_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

  logic tick, restart, done, vote, vote_now, bit_end;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, chk_q, chk_d;
`endif

  uart_ovs_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk_i     (CLOCK_125_p),
    .rst_ni    (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Ticks are numbered 1..OVERSAMPLE within a bit; tick_cnt_q holds how many
  // have elapsed, so the tick being consumed now is tick_cnt_q + 1.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    restart    = 1'b0;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    tick_num = tick_cnt_q + 1'b1;
    vote     = maj3(samp_a_q, samp_b_q, rx_sync_q);
    vote_now = tick && (tick_num == T_C);
    bit_end  = tick && (tick_num == T_END);

    if (tick) begin
      tick_cnt_d = bit_end ? '0 : tick_num;
      if (tick_num == T_A) samp_a_d = rx_sync_q;
      if (tick_num == T_B) samp_b_d = rx_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
        par_d      = 1'b0;
`endif
        // Only a real falling edge starts a frame; a line stuck low never does.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = ST_START;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (vote_now && vote) state_d = ST_IDLE;  // false start
        else if (bit_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ vote;
`endif
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (vote_now) par_d = par_q ^ vote;
        if (bit_end)  state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave at the stop-bit vote so a back-to-back start edge is not missed.
        if (vote_now) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    chk_d   = chk_q;
`endif
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        ferr_d  = ~vote;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        chk_d   = ~par_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_125_p or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      chk_q      <= 1'b1;
`endif
    end else begin
      rx_meta_q  <= Rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign check_parity = chk_q;
`else
  assign check_parity = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed bench for uart_rx_ovs with a scoreboard queue.
// Works with and without UART_RX_PARITY_EN defined.
`timescale 1ns/1ps
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int DIV     = 4;
  localparam int OVS     = 16;
  localparam int BIT_CYC = DIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
  localparam bit HAS_PAR    = 1'b1;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
  localparam bit HAS_PAR    = 1'b0;
`endif
  localparam int STOP_IDX  = FRAME_BITS - 1;
  // Posedges from the edge before the start bit is driven to the edge just
  // before the stop-bit vote is consumed: 2 sync edges, then one tick per DIV.
  localparam int DONE_WAIT = 2 + (OVS * STOP_IDX + VOTE_TICK_C) * DIV;
  localparam int W = 10;  // {frame_err, check_parity, data}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, Rx, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, check_parity, frame_err, overrun;
  uart_state_e dbg_state;

  always #4 clk = ~clk;

  uart_rx_ovs #(.OVS_DIV(DIV), .OVERSAMPLE(OVS)) dut (
    .CLOCK_125_p  (clk),
    .rst          (rst),
    .Rx           (Rx),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .check_parity (check_parity),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic chk_if_par, input logic ferr);
    logic chk;
    chk = HAS_PAR ? chk_if_par : 1'b1;
    exp_q.push_back({ferr, chk, d});
  endtask

  // Monitor: inputs change only just after posedge, so negedge values equal
  // those seen by the DUT at the next posedge.
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got data %0h ferr %0b chk %0b, expected none",
                 rx_data, frame_err, check_parity);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rx_data",      32'(rx_data),      32'(e[7:0]));
        check("check_parity", 32'(check_parity), 32'(e[8]));
        check("frame_err",    32'(frame_err),    32'(e[9]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input bit hold_low);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    if (HAS_PAR) drive_bit(par_bit);
    drive_bit(stop_bit);
    Rx = hold_low ? 1'b0 : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * FRAME_BITS * BIT_CYC && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},     32'(rx_valid),     32'd0);
    check({tag, "_rx_data"},      32'(rx_data),      32'd0);
    check({tag, "_check_parity"}, 32'(check_parity), 32'd1);
    check({tag, "_frame_err"},    32'(frame_err),    32'd0);
    check({tag, "_overrun"},      32'(overrun),      32'd0);
    check({tag, "_state"},        32'(dbg_state),    32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(90000 * 8);
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; Rx = 1'b1; rx_ready = 1'b0;
    idle(5);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(BIT_CYC);

    // Clean byte, good parity, consumer always ready.
    rx_ready = 1'b1;
    expect_byte(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);

    // Wrong parity bit.
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_basic");

    // Short low glitch is a false start.
    @(posedge clk); #1;
    Rx = 1'b0;
    idle(3 * DIV);
    Rx = 1'b1;
    idle(2 * BIT_CYC);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    check("glitch_valid", 32'(rx_valid),  32'd0);

    // Framing error, then clean byte after the line idles high.
    expect_byte(8'h81, 1'b1, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    idle(BIT_CYC);
    expect_byte(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_ferr");

    // Line stuck low: one frame_err byte, nothing further.
    expect_byte(8'h00, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    idle(3 * FRAME_BITS * BIT_CYC);
    check("stuck_low_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stuck_low_valid", 32'(rx_valid),  32'd0);
    Rx = 1'b1;
    idle(BIT_CYC);
    wait_drain("drain_stuck");

    // Overrun: consumer stalled across two bytes.
    rx_ready = 1'b0;
    expect_byte(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("ovr_overrun", 32'(overrun),  32'd1);
    check("ovr_data",    32'(rx_data),  32'h11);
    check("ovr_valid",   32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_drain("drain_ovr");
    idle(2);
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    idle(2);
    check("ovr_reset_clears", 32'(overrun), 32'd0);
    rst = 1'b1;
    idle(BIT_CYC);

    // Handshake of the old byte coincides with completion of the new one.
    rx_ready = 1'b0;
    expect_byte(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    expect_byte(8'h22, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (DONE_WAIT) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(2);
    check("race_overrun", 32'(overrun),  32'd0);
    check("race_valid",   32'(rx_valid), 32'd1);
    check("race_data",    32'(rx_data),  32'h22);
    rx_ready = 1'b1;
    wait_drain("drain_race");

    // Reset in the middle of data bit 4 of 0xF0.
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    Rx = 1'b1;
    idle(BIT_CYC / 2);
    rst = 1'b0;
    idle(3);
    check_reset_outputs("midframe_reset");
    rst = 1'b1;
    idle(2 * BIT_CYC);
    expect_byte(8'h0F, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_final");
    idle(FRAME_BITS * BIT_CYC);
    check("final_state", 32'(dbg_state), 32'(ST_IDLE));
    check("final_valid", 32'(rx_valid),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 The block SHALL have parameter OVS_DIV, default 814, giving CLOCK_125_p cycles per oversample tick (16x of 9600 baud at 125 MHz).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, giving oversample ticks per bit.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 The block SHALL have port CLOCK_125_p, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port Rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the byte.
REQ-008 The block SHALL have port rx_data, output, 8 bits: received byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-010 The block SHALL have port check_parity, output, 1 bit: 1 = no parity error on the current byte.
REQ-011 The block SHALL have port frame_err, output, 1 bit: stop bit sampled low on the current byte.
REQ-012 The block SHALL have port overrun, output, 1 bit, sticky: a byte was lost.

Function
REQ-013 Rx SHALL pass through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-014 The frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-015 The tick generator SHALL pulse for one cycle every OVS_DIV cycles and SHALL restart its count on entry to START.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-017 In IDLE, a synchronized 1->0 transition SHALL cause entry to START.
REQ-018 START SHALL vote at ticks 7/8/9: a 0 SHALL go to DATA; a 1 SHALL be a false start and return to IDLE with no output change.
REQ-019 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9 of that bit.
REQ-020 DATA SHALL shift in exactly 8 bits using a 3-bit counter; after bit 7 it SHALL go to PARITY.
REQ-021 PARITY SHALL compute the XOR of the 8 data bits and the parity bit; a result of 0 SHALL mean OK.
REQ-022 STOP SHALL return to IDLE immediately after the tick-9 vote, without waiting for the end of the bit.
REQ-023 On that STOP cycle, rx_data, check_parity and frame_err SHALL update and rx_valid SHALL set to 1 (latency = vote point of the stop bit).
REQ-024 A byte with frame_err=1 SHALL still be delivered.
REQ-025 rx_valid SHALL clear in the cycle after rx_valid && rx_ready are both high.
REQ-026 If rx_valid=1 and rx_ready=0 when a new byte completes, the old byte SHALL be kept, the new byte dropped, and overrun set; overrun SHALL clear only on reset.
REQ-027 If the handshake and a new completion fall in the same cycle, the new byte SHALL load, rx_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-028 A line held low SHALL give one byte with frame_err=1, then no further frames until Rx returns high and falls again.

Reset
REQ-029 Reset SHALL drive: FSM IDLE, counters 0, synchronizer 1s, rx_data 0, rx_valid 0, check_parity 1, frame_err 0, overrun 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no partial byte delivered.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: behaviour SHALL be as above (11-bit frame).
REQ-032 Macro UART_RX_PARITY_EN undefined: PARITY SHALL be removed (10-bit frame, DATA goes to STOP) and check_parity SHALL be constant 1.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef, the OVERSAMPLE default, the vote tick constants (7/8/9) and the frame bit-count constants.
REQ-034 Sub-module uart_ovs_tick SHALL be the tick counter (OVS_DIV, restart input, tick output); the synchronizer stays inline.

Verification
REQ-035 With parity: send 0xA5, parity 0, stop 1, rx_ready=1 -> rx_data=0xA5, check_parity=1, frame_err=0, one rx_valid pulse.
REQ-036 Send 0x3C with parity bit 1 -> rx_data=0x3C, check_parity=0.
REQ-037 Send a 3-tick low glitch in idle -> no rx_valid, FSM back in IDLE.
REQ-038 Send 0x81 with stop bit 0 -> rx_data=0x81, frame_err=1; with Rx then high, a following 0x55 is received cleanly.
REQ-039 With rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1; same sequence with rx_ready pulsed at the completion cycle -> rx_data=0x22, overrun=0.
REQ-040 Assert rst during bit 4 of 0xF0, release, then send 0x0F -> only 0x0F delivered.
